muldiv_unit: RTL

Iterative multiply/divide unit implementing the full M-extension operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for an XLEN-wide datapath. It sits beside the combinational ALU in the execute stage and handles the multi-cycle M-extension operations. Operands enter through a valid/ready handshake and the result leaves through a second valid/ready handshake. Normal operations use a radix-2 shift-add or shift-subtract loop: one bit per cycle, fixed latency. Division-by-zero and signed-overflow cases complete early.

---
 rtl/muldiv_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit for the M-extension ops.
// One result bit per cycle. Divide-by-zero and signed overflow finish straight after the accept edge.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(XLEN + 1);
  state_t state;
  logic [2:0] fn;
  logic neg;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] b;
  logic [2*XLEN-1:0] acc;
  logic is_div, sgn_a, sgn_b, sa, sb, div0, ovf;
  logic [XLEN-1:0] mag_a, mag_b, special, quo, rm, quo_s, rm_s, res;
  logic [XLEN:0] msum, shifted, diff;
  logic [2*XLEN-1:0] mul_next, div_next, nxt, full;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign is_div = funct3[2];
  assign sgn_a = is_div ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign sgn_b = is_div ? !funct3[0] : funct3[1:0] == 2'b01;
  assign sa = sgn_a & op_a[XLEN-1];
  assign sb = sgn_b & op_b[XLEN-1];
  assign mag_a = sa ? -op_a : op_a;
  assign mag_b = sb ? -op_b : op_b;
  assign div0 = is_div && op_b == '0;
  assign ovf = is_div && !funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && &op_b;
  assign special = div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
  // acc holds {high product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign msum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : '0);
  assign mul_next = {msum, acc[XLEN-1:1]};
  assign shifted = acc[2*XLEN-1:XLEN-1];
  assign diff = shifted - {1'b0, b};
  assign div_next = diff[XLEN] ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign nxt = fn[2] ? div_next : mul_next;
  assign full = neg ? -nxt : nxt;
  assign quo = nxt[XLEN-1:0];
  assign rm = nxt[2*XLEN-1:XLEN];
  assign quo_s = neg ? -quo : quo;
  assign rm_s = neg ? -rm : rm;
  assign res = fn[2] ? (fn[1] ? rm_s : quo_s)
                     : (fn == 3'b000 ? full[XLEN-1:0] : full[2*XLEN-1:XLEN]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fn <= '0;
      neg <= 1'b0;
      cnt <= '0;
      b <= '0;
      acc <= '0;
      out <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          fn <= funct3;
          neg <= (is_div && funct3[1]) ? sa : sa ^ sb;
          b <= is_div ? mag_b : mag_a;
          acc <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
          cnt <= CW'(XLEN);
          if (div0 || ovf) begin
            out <= special;
            state <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          acc <= nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            out <= res;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
